// File: rtl/alu_share_arbiter_pkg.sv
// Shared types for the ALU-sharing arbiter: ALU opcodes, the response port id,
// and a small helper that maps a one-hot grant to the winning port.
package alu_share_arbiter_pkg;

    typedef enum logic [3:0] {
        ALU_ADD  = 4'd0,
        ALU_SUB  = 4'd1,
        ALU_SLL  = 4'd2,
        ALU_SLT  = 4'd3,
        ALU_SLTU = 4'd4,
        ALU_XOR  = 4'd5,
        ALU_SRL  = 4'd6,
        ALU_SRA  = 4'd7,
        ALU_OR   = 4'd8,
        ALU_AND  = 4'd9
    } alu_op_e;

    typedef enum logic {
        ARB_P0 = 1'b0,
        ARB_P1 = 1'b1
    } arb_port_e;

    // Grant is one-hot; bit 1 set means port 1 won, anything else maps to port 0.
    function automatic arb_port_e port_of(input logic [1:0] grant);
        return grant[1] ? ARB_P1 : ARB_P0;
    endfunction

endpackage

// File: rtl/alu_share_arbiter_alu.sv
// Combinational ALU shared by both requesters. Shift amounts come from
// b[4:0]; opcodes outside the defined set produce zero.
module alu_share_arbiter_alu
    import alu_share_arbiter_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  alu_op_e          op,
    output logic [WIDTH-1:0] result
);

    logic [4:0] shamt;

    assign shamt = b[4:0];

    // Single-cycle operation decode.
    always_comb begin
        result = '0;
        case (op)
            ALU_ADD:  result = a + b;
            ALU_SUB:  result = a - b;
            ALU_SLL:  result = a << shamt;
            ALU_SLT:  result = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
            ALU_SLTU: result = {{(WIDTH-1){1'b0}}, (a < b)};
            ALU_XOR:  result = a ^ b;
            ALU_SRL:  result = a >> shamt;
            ALU_SRA:  result = $signed(a) >>> shamt;
            ALU_OR:   result = a | b;
            ALU_AND:  result = a & b;
            default:  result = '0;
        endcase
    end

endmodule

// File: rtl/alu_share_arbiter.sv
// Shares one ALU between the execute stage (port 0) and an auxiliary helper
// (port 1). At most one request is granted per cycle; its result lands in a
// single registered response slot tagged with the winning port.
//
// Arbiter state (no separate state encoding):
//   rr_last    | port granted most recently (reset to 1 so port 0 goes first)
//   starve_cnt | consecutive port-1 losses to port 0, fixed-priority mode only
module alu_share_arbiter
    import alu_share_arbiter_pkg::*;
#(
    parameter int WIDTH      = 32,
    parameter int TAG_W      = 4,
    parameter int RR_MODE    = 0,
    parameter int STARVE_MAX = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [1:0]                 req_valid,
    output logic [1:0]                 req_ready,
    input  logic [1:0][WIDTH-1:0]      req_a,
    input  logic [1:0][WIDTH-1:0]      req_b,
    input  alu_op_e [1:0]              req_op,
    input  logic [1:0][TAG_W-1:0]      req_tag,
    output logic                       rsp_valid,
    input  logic                       rsp_ready,
    output arb_port_e                  rsp_id,
    output logic [TAG_W-1:0]           rsp_tag,
    output logic [WIDTH-1:0]           rsp_result
);

    localparam int SC_W = $clog2(STARVE_MAX + 1);

    logic             rr_last;
    logic [SC_W-1:0]  starve_cnt;
    logic             can_accept;
    logic             p1_wins;
    logic [1:0]       grant;
    logic [WIDTH-1:0] alu_a;
    logic [WIDTH-1:0] alu_b;
    alu_op_e          alu_op;
    logic [WIDTH-1:0] alu_result;

    // The slot can take a new result when empty or when it drains this cycle.
    assign can_accept = !rsp_valid || rsp_ready;

    // Pick the winner; grants are suppressed while reset is asserted.
    always_comb begin
        p1_wins = 1'b0;
        if (RR_MODE != 0) begin
            p1_wins = req_valid[1] && (!req_valid[0] || !rr_last);
        end else begin
            p1_wins = req_valid[1] &&
                      (!req_valid[0] || (starve_cnt == SC_W'(STARVE_MAX)));
        end
        grant = 2'b00;
        if (can_accept && !rst) begin
            grant[1] = p1_wins;
            grant[0] = req_valid[0] && !p1_wins;
        end
    end

    assign req_ready = grant;

    // Steer the winning operands into the shared ALU.
    always_comb begin
        alu_a  = grant[1] ? req_a[1]  : req_a[0];
        alu_b  = grant[1] ? req_b[1]  : req_b[0];
        alu_op = grant[1] ? req_op[1] : req_op[0];
    end

    alu_share_arbiter_alu #(
        .WIDTH (WIDTH)
    ) u_alu (
        .a      (alu_a),
        .b      (alu_b),
        .op     (alu_op),
        .result (alu_result)
    );

    // Arbiter history: last winner and port-1 starvation count.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rr_last    <= 1'b1;
            starve_cnt <= '0;
        end else begin
            if (|grant) begin
                rr_last <= grant[1];
            end
            if (RR_MODE != 0) begin
                starve_cnt <= '0;
            end else if (grant[1]) begin
                starve_cnt <= '0;
            end else if (grant[0] && req_valid[1] &&
                         (starve_cnt != SC_W'(STARVE_MAX))) begin
                starve_cnt <= starve_cnt + SC_W'(1);
            end
        end
    end

    // Response slot: loads on a grant, clears when drained without a refill,
    // and otherwise holds every field stable.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rsp_valid  <= 1'b0;
            rsp_id     <= ARB_P0;
            rsp_tag    <= '0;
            rsp_result <= '0;
        end else if (can_accept) begin
            rsp_valid <= |grant;
            if (|grant) begin
                rsp_id     <= port_of(grant);
                rsp_tag    <= grant[1] ? req_tag[1] : req_tag[0];
                rsp_result <= alu_result;
            end
        end
    end

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Directed bench: one fixed-priority and one round-robin arbiter share the
// same request stimulus; each scenario checks the instance it targets.
module tb_alu_share_arbiter;
    import alu_share_arbiter_pkg::*;

    logic                 clk = 1'b0;
    logic                 rst;
    logic [1:0]           req_valid;
    logic [1:0][31:0]     req_a;
    logic [1:0][31:0]     req_b;
    alu_op_e [1:0]        req_op;
    logic [1:0][3:0]      req_tag;
    logic                 rsp_ready;

    logic [1:0]  req_ready_f,  req_ready_r;
    logic        rsp_valid_f,  rsp_valid_r;
    arb_port_e   rsp_id_f,     rsp_id_r;
    logic [3:0]  rsp_tag_f,    rsp_tag_r;
    logic [31:0] rsp_result_f, rsp_result_r;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    alu_share_arbiter #(.WIDTH(32), .TAG_W(4), .RR_MODE(0), .STARVE_MAX(4)) dut_fix (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready_f),
        .req_a(req_a), .req_b(req_b), .req_op(req_op), .req_tag(req_tag),
        .rsp_valid(rsp_valid_f), .rsp_ready(rsp_ready), .rsp_id(rsp_id_f),
        .rsp_tag(rsp_tag_f), .rsp_result(rsp_result_f)
    );

    alu_share_arbiter #(.WIDTH(32), .TAG_W(4), .RR_MODE(1), .STARVE_MAX(4)) dut_rr (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready_r),
        .req_a(req_a), .req_b(req_b), .req_op(req_op), .req_tag(req_tag),
        .rsp_valid(rsp_valid_r), .rsp_ready(rsp_ready), .rsp_id(rsp_id_r),
        .rsp_tag(rsp_tag_r), .rsp_result(rsp_result_r)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int p, input alu_op_e op, input logic [31:0] a,
                           input logic [31:0] b, input logic [3:0] tag);
        req_op[p]  = op;
        req_a[p]   = a;
        req_b[p]   = b;
        req_tag[p] = tag;
    endtask

    task automatic test_reset();
        rst       = 1'b1;
        rsp_ready = 1'b1;
        req_valid = 2'b11;
        set_req(0, ALU_ADD, 32'd1, 32'd2, 4'd1);
        set_req(1, ALU_ADD, 32'd3, 32'd4, 4'd2);
        tick();
        tick();
        checks++; if (rsp_valid_f !== 1'b0) begin failures++; $display("FAIL reset_rsp_valid got=%b exp=0", rsp_valid_f); end
        checks++; if (req_ready_f !== 2'b00) begin failures++; $display("FAIL reset_req_ready_fix got=%b exp=00", req_ready_f); end
        checks++; if (req_ready_r !== 2'b00) begin failures++; $display("FAIL reset_req_ready_rr got=%b exp=00", req_ready_r); end
        checks++; if (rsp_result_f !== 32'd0) begin failures++; $display("FAIL reset_result got=%h exp=0", rsp_result_f); end
        checks++; if (rsp_tag_f !== 4'd0) begin failures++; $display("FAIL reset_tag got=%h exp=0", rsp_tag_f); end
        checks++; if (rsp_id_f !== ARB_P0) begin failures++; $display("FAIL reset_id got=%0d exp=0", rsp_id_f); end

        rst = 1'b0;
        #1;
        checks++; if (req_ready_f !== 2'b01) begin failures++; $display("FAIL first_grant_fix got=%b exp=01", req_ready_f); end
        checks++; if (req_ready_r !== 2'b01) begin failures++; $display("FAIL first_grant_rr got=%b exp=01", req_ready_r); end

        // Fill the slot and hold it, then reset mid-cycle.
        rsp_ready = 1'b0;
        tick();
        checks++; if (rsp_valid_f !== 1'b1) begin failures++; $display("FAIL pre_reset_valid got=%b exp=1", rsp_valid_f); end
        #2;
        rst = 1'b1;
        #1;
        checks++; if (rsp_valid_f !== 1'b0) begin failures++; $display("FAIL async_reset_valid_fix got=%b exp=0", rsp_valid_f); end
        checks++; if (rsp_valid_r !== 1'b0) begin failures++; $display("FAIL async_reset_valid_rr got=%b exp=0", rsp_valid_r); end
        checks++; if (req_ready_f !== 2'b00) begin failures++; $display("FAIL async_reset_ready got=%b exp=00", req_ready_f); end

        tick();
        rst       = 1'b0;
        rsp_ready = 1'b1;
        #1;
        checks++; if (req_ready_f !== 2'b01) begin failures++; $display("FAIL release_grant_fix got=%b exp=01", req_ready_f); end
        checks++; if (req_ready_r !== 2'b01) begin failures++; $display("FAIL release_grant_rr got=%b exp=01", req_ready_r); end
        tick();
        req_valid = 2'b00;
    endtask

    task automatic test_single_port();
        rsp_ready = 1'b1;
        req_valid = 2'b10;
        set_req(1, ALU_ADD, 32'd5, 32'd7, 4'd3);
        #1;
        checks++; if (req_ready_f !== 2'b10) begin failures++; $display("FAIL single_ready got=%b exp=10", req_ready_f); end
        tick();
        req_valid = 2'b00;
        checks++; if (rsp_valid_f !== 1'b1) begin failures++; $display("FAIL single_valid got=%b exp=1", rsp_valid_f); end
        checks++; if (rsp_result_f !== 32'd12) begin failures++; $display("FAIL single_result got=%0d exp=12", rsp_result_f); end
        checks++; if (rsp_id_f !== ARB_P1) begin failures++; $display("FAIL single_id got=%0d exp=1", rsp_id_f); end
        checks++; if (rsp_tag_f !== 4'd3) begin failures++; $display("FAIL single_tag got=%0d exp=3", rsp_tag_f); end
    endtask

    task automatic test_backpressure();
        req_valid = 2'b00;
        rsp_ready = 1'b1;
        tick();
        checks++; if (rsp_valid_f !== 1'b0) begin failures++; $display("FAIL drain_clear got=%b exp=0", rsp_valid_f); end

        set_req(0, ALU_SUB, 32'd10, 32'd3, 4'd5);
        req_valid = 2'b01;
        rsp_ready = 1'b0;
        #1;
        checks++; if (req_ready_f !== 2'b01) begin failures++; $display("FAIL bp_first_ready got=%b exp=01", req_ready_f); end
        tick();
        set_req(0, ALU_ADD, 32'd1, 32'd1, 4'd6);
        for (int i = 0; i < 3; i++) begin
            checks++; if (rsp_valid_f !== 1'b1) begin failures++; $display("FAIL bp_hold_valid cyc=%0d got=%b exp=1", i, rsp_valid_f); end
            checks++; if (rsp_result_f !== 32'd7) begin failures++; $display("FAIL bp_hold_result cyc=%0d got=%0d exp=7", i, rsp_result_f); end
            checks++; if (rsp_tag_f !== 4'd5) begin failures++; $display("FAIL bp_hold_tag cyc=%0d got=%0d exp=5", i, rsp_tag_f); end
            checks++; if (req_ready_f !== 2'b00) begin failures++; $display("FAIL bp_hold_ready cyc=%0d got=%b exp=00", i, req_ready_f); end
            tick();
        end
        checks++; if (rsp_result_f !== 32'd7) begin failures++; $display("FAIL bp_still_held got=%0d exp=7", rsp_result_f); end
        rsp_ready = 1'b1;
        #1;
        checks++; if (req_ready_f !== 2'b01) begin failures++; $display("FAIL bp_release_ready got=%b exp=01", req_ready_f); end
        tick();
        req_valid = 2'b00;
        checks++; if (rsp_valid_f !== 1'b1) begin failures++; $display("FAIL bp_reload_valid got=%b exp=1", rsp_valid_f); end
        checks++; if (rsp_result_f !== 32'd2) begin failures++; $display("FAIL bp_reload_result got=%0d exp=2", rsp_result_f); end
        checks++; if (rsp_tag_f !== 4'd6) begin failures++; $display("FAIL bp_reload_tag got=%0d exp=6", rsp_tag_f); end
        tick();
        checks++; if (rsp_valid_f !== 1'b0) begin failures++; $display("FAIL bp_slot_clear got=%b exp=0", rsp_valid_f); end
    endtask

    task automatic test_fixed_starvation();
        logic [1:0]  exp_ready;
        arb_port_e   exp_id;
        logic [31:0] exp_res;
        set_req(0, ALU_ADD, 32'd1, 32'd1, 4'd0);
        set_req(1, ALU_XOR, 32'hF0, 32'hFF, 4'd1);
        req_valid = 2'b11;
        rsp_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            exp_ready = (i % 5 == 4) ? 2'b10 : 2'b01;
            exp_id    = (i % 5 == 4) ? ARB_P1 : ARB_P0;
            exp_res   = (i % 5 == 4) ? 32'h0F : 32'd2;
            #1;
            checks++; if (req_ready_f !== exp_ready) begin failures++; $display("FAIL starve_grant cyc=%0d got=%b exp=%b", i, req_ready_f, exp_ready); end
            tick();
            checks++; if (rsp_id_f !== exp_id) begin failures++; $display("FAIL starve_id cyc=%0d got=%0d exp=%0d", i, rsp_id_f, exp_id); end
            checks++; if (rsp_result_f !== exp_res) begin failures++; $display("FAIL starve_result cyc=%0d got=%h exp=%h", i, rsp_result_f, exp_res); end
        end
        req_valid = 2'b00;
    endtask

    task automatic test_round_robin();
        logic [1:0]  exp_ready;
        arb_port_e   exp_id;
        logic [31:0] exp_res;
        set_req(0, ALU_SRA, 32'h8000_0000, 32'd4, 4'd2);
        set_req(1, ALU_SLTU, 32'd1, 32'd2, 4'd3);
        rsp_ready = 1'b1;
        req_valid = 2'b10;
        tick();
        req_valid = 2'b11;
        for (int i = 0; i < 4; i++) begin
            exp_ready = (i % 2 == 0) ? 2'b01 : 2'b10;
            exp_id    = (i % 2 == 0) ? ARB_P0 : ARB_P1;
            exp_res   = (i % 2 == 0) ? 32'hF800_0000 : 32'd1;
            #1;
            checks++; if (req_ready_r !== exp_ready) begin failures++; $display("FAIL rr_grant cyc=%0d got=%b exp=%b", i, req_ready_r, exp_ready); end
            tick();
            checks++; if (rsp_id_r !== exp_id) begin failures++; $display("FAIL rr_id cyc=%0d got=%0d exp=%0d", i, rsp_id_r, exp_id); end
            checks++; if (rsp_result_r !== exp_res) begin failures++; $display("FAIL rr_result cyc=%0d got=%h exp=%h", i, rsp_result_r, exp_res); end
        end
        req_valid = 2'b00;
        tick();
    endtask

    task automatic test_op_sweep();
        alu_op_e     ops[7];
        logic [31:0] va[7];
        logic [31:0] vb[7];
        logic [31:0] ve[7];
        ops = '{ALU_SLL, ALU_SLT, ALU_SRL, ALU_AND, ALU_OR, ALU_SRA, alu_op_e'(4'd12)};
        va  = '{32'd1, 32'hFFFF_FFFF, 32'h40, 32'hF0F0, 32'h0F, 32'h8000_0000, 32'd5};
        vb  = '{32'd31, 32'd0, 32'h25, 32'hFF00, 32'hF0, 32'h24, 32'd3};
        ve  = '{32'h8000_0000, 32'd1, 32'd2, 32'hF000, 32'hFF, 32'hF800_0000, 32'd0};
        rsp_ready = 1'b1;
        for (int p = 0; p < 2; p++) begin
            for (int v = 0; v < 7; v++) begin
                set_req(p, ops[v], va[v], vb[v], 4'(v));
                req_valid = (p == 0) ? 2'b01 : 2'b10;
                tick();
                checks++; if (rsp_result_f !== ve[v]) begin failures++; $display("FAIL op_sweep port=%0d vec=%0d got=%h exp=%h", p, v, rsp_result_f, ve[v]); end
                checks++; if (rsp_id_f !== arb_port_e'(p)) begin failures++; $display("FAIL op_sweep_id port=%0d vec=%0d got=%0d exp=%0d", p, v, rsp_id_f, p); end
            end
        end
        req_valid = 2'b00;
        tick();
    endtask

    initial begin
        req_valid = 2'b00;
        rsp_ready = 1'b1;
        req_a     = '0;
        req_b     = '0;
        req_tag   = '0;
        req_op[0] = ALU_ADD;
        req_op[1] = ALU_ADD;
        test_reset();
        test_single_port();
        test_backpressure();
        test_fixed_starvation();
        test_round_robin();
        test_op_sweep();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
